// File: rtl/halflife_decay_timer.sv
// Half-life decay timer: a loaded count is halved once per programmable period
// until it reaches zero, with start/stop control, trim and a halvings counter.
module halflife_decay_timer #(
    parameter int WIDTH  = 8,
    parameter int PER_W  = 16,
    parameter int HCNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              start,
    input  logic              stop,
    input  logic              up,
    input  logic              down,
    input  logic [PER_W-1:0]  period,
    output logic [WIDTH-1:0]  value,
    output logic              alive,
    output logic              running,
    output logic              done,
    output logic [HCNT_W-1:0] halvings
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH:0]    W1_ONE  = 1;
    localparam logic [PER_W-1:0]  PER_ONE = 1;
    localparam logic [HCNT_W-1:0] H_ONE   = 1;
    localparam logic [HCNT_W-1:0] H_MAX   = '1;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [HCNT_W-1:0] halvings_q, halvings_d;
    logic [PER_W-1:0]  phase_q, phase_d;
    logic [PER_W-1:0]  per_q, per_d;

    logic [WIDTH:0]    inc_w, dec_w;
    logic [WIDTH-1:0]  adj;
    logic              tick;
    logic              done_c;

    // Trim runs one bit wider so overflow and borrow can be clamped.
    always_comb begin
        inc_w = {1'b0, value_q} + W1_ONE;
        dec_w = {1'b0, value_q} - W1_ONE;
        adj   = value_q;
        if (up && !down) begin
            adj = inc_w[WIDTH] ? '1 : inc_w[WIDTH-1:0];
        end else if (down && !up) begin
            adj = dec_w[WIDTH] ? '0 : dec_w[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        halvings_d = halvings_q;
        phase_d    = phase_q;
        per_d      = per_q;
        tick       = 1'b0;
        done_c     = 1'b0;
        if (load) begin
            value_d    = load_val;
            phase_d    = '0;
            halvings_d = '0;
            state_d    = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    value_d = adj;
                    if (start) begin
                        state_d = S_RUN;
                        per_d   = (period == '0) ? PER_ONE : period;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else begin
                        tick    = (phase_q == per_q - PER_ONE);
                        phase_d = tick ? '0 : phase_q + PER_ONE;
                        if (tick) begin
                            value_d = adj >> 1;
                            if (halvings_q != H_MAX) begin
                                halvings_d = halvings_q + H_ONE;
                            end
                        end else begin
                            value_d = adj;
                        end
                        if (value_d == '0) begin
                            state_d = S_DONE;
                            done_c  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    value_d = value_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            value_q    <= '0;
            halvings_q <= '0;
            phase_q    <= '0;
            per_q      <= PER_ONE;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            halvings_q <= halvings_d;
            phase_q    <= phase_d;
            per_q      <= per_d;
        end
    end

    assign value    = value_q;
    assign alive    = (value_q != '0);
    assign running  = (state_q == S_RUN);
    assign done     = done_c;
    assign halvings = halvings_q;

endmodule
